// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the instruction
// fetch port (I) and the load/store port (D). D wins by default; a starvation
// counter forces an I grant once I has been denied MAX_WAIT cycles in a row.
// Read data returns one cycle after the grant and is routed to its owner.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 30,
  parameter int MAX_WAIT   = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction fetch port
  input  logic                  i_ireq,
  input  logic [ADDR_WIDTH-1:0] i_iaddr,
  output logic                  o_igrant,
  output logic                  o_irvalid,
  output logic [31:0]           o_irdata,
  // data / LSU port
  input  logic                  i_dreq,
  input  logic [ADDR_WIDTH-1:0] i_daddr,
  input  logic                  i_dwe,
  input  logic [3:0]            i_dmask,
  input  logic [31:0]           i_dwdata,
  output logic                  o_dgrant,
  output logic                  o_drvalid,
  output logic [31:0]           o_drdata,
  // shared memory port
  output logic                  o_mem_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_mask,
  output logic [31:0]           o_mem_data,
  input  logic [31:0]           i_mem_data
);

  // Who owns the read data arriving from the RAM next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [CNT_WIDTH-1:0] WAIT_LIMIT = CNT_WIDTH'(MAX_WAIT);

  logic [CNT_WIDTH-1:0] wait_cnt;
  logic [CNT_WIDTH-1:0] wait_cnt_next;
  owner_t               rsp_owner;
  owner_t               rsp_owner_next;
  logic                 force_i;
  logic                 igrant;
  logic                 dgrant;

  // Arbitration: D has priority unless I has starved long enough; no grants in reset.
  always_comb begin
    force_i = (wait_cnt == WAIT_LIMIT);
    igrant  = !rst && i_ireq && (!i_dreq || force_i);
    dgrant  = !rst && i_dreq && !igrant;
  end

  assign o_igrant = igrant;
  assign o_dgrant = dgrant;

  // Memory port mux: the granted requester drives the RAM, otherwise all zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    o_mem_en   = 1'b0;
    o_mem_addr = '0;
    o_mem_we   = 1'b0;
    o_mem_mask = 4'b0000;
    o_mem_data = 32'h0;
    if (igrant) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_iaddr;
    end else if (dgrant) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_daddr;
      o_mem_we   = i_dwe;
      o_mem_mask = i_dwe ? i_dmask : 4'b0000;
      o_mem_data = i_dwdata;
    end
  end

  // Next-state logic for the starvation counter and the response owner.
  always_comb begin
    wait_cnt_next  = wait_cnt;
    rsp_owner_next = OWN_NONE;

    // The counter only runs while I is actually waiting; any grant or a
    // dropped request restarts it. It saturates, though the forced grant at
    // the limit means saturation is never held for more than one cycle.
    if (!i_ireq || igrant) begin
      wait_cnt_next = '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt_next = wait_cnt + 1'b1;
    end

    // Writes return nothing, so they leave no owner behind.
    if (igrant) begin
      rsp_owner_next = OWN_I;
    end else if (dgrant && !i_dwe) begin
      rsp_owner_next = OWN_D;
    end
  end

  // State register; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      rsp_owner <= OWN_NONE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      wait_cnt  <= wait_cnt_next;
      rsp_owner <= rsp_owner_next;
    end
  end

  // Response routing: RAM read data goes to whoever owned last cycle's read.
  assign o_irvalid = (rsp_owner == OWN_I);
  assign o_drvalid = (rsp_owner == OWN_D);
  assign o_irdata  = o_irvalid ? i_mem_data : 32'h0;
  assign o_drdata  = o_drvalid ? i_mem_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural RAM sits on the memory
// port, an independent arbitration model predicts grants and port values,
// and expected responses are queued at grant time and popped one cycle later.
module tb_mem_arbiter;

  localparam int AW = 30;
  localparam int MW = 4;
  localparam int CW = 8;

  localparam logic [1:0] EXP_NONE = 2'd0;
  localparam logic [1:0] EXP_I    = 2'd1;
  localparam logic [1:0] EXP_D    = 2'd2;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ireq = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic          igrant, irvalid;
  logic [31:0]   irdata;
  logic          dreq = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic          dwe = 1'b0;
  logic [3:0]    dmask = 4'b0;
  logic [31:0]   dwdata = 32'h0;
  logic          dgrant, drvalid;
  logic [31:0]   drdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_mask;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;

  logic [31:0]   ram     [256];
  logic [31:0]   ref_mem [256];
  rsp_t          sb [$];
  int            m_wait = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_ireq     (ireq),
    .i_iaddr    (iaddr),
    .o_igrant   (igrant),
    .o_irvalid  (irvalid),
    .o_irdata   (irdata),
    .i_dreq     (dreq),
    .i_daddr    (daddr),
    .i_dwe      (dwe),
    .i_dmask    (dmask),
    .i_dwdata   (dwdata),
    .o_dgrant   (dgrant),
    .o_drvalid  (drvalid),
    .o_drdata   (drdata),
    .o_mem_en   (mem_en),
    .o_mem_addr (mem_addr),
    .o_mem_we   (mem_we),
    .o_mem_mask (mem_mask),
    .o_mem_data (mem_wdata),
    .i_mem_data (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency and byte writes.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[7:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: drive, check at the falling edge, update model, advance.
  task automatic cycle(input logic ir, input logic [AW-1:0] ia,
                       input logic dr, input logic [AW-1:0] da, input logic we,
                       input logic [3:0] mk, input logic [31:0] wd,
                       input logic pulse_rst);
    rsp_t r;
    logic eig, edg, frc;
    logic [AW-1:0] eaddr;
    ireq = ir; iaddr = ia; dreq = dr; daddr = da; dwe = we; dmask = mk; dwdata = wd;
    @(negedge clk);

    // Response owed from last cycle's grant.
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      r = sb.pop_front();
      check("irvalid", irvalid, r.owner == EXP_I);
      check("drvalid", drvalid, r.owner == EXP_D);
      if (r.owner == EXP_I) check("irdata", irdata, r.data);
      if (r.owner == EXP_D) check("drdata", drdata, r.data);
    end

    // Arbitration model.
    frc = (m_wait == MW);
    eig = !rst && ir && (!dr || frc);
    edg = !rst && dr && !eig;
    eaddr = eig ? ia : (edg ? da : '0);
    check("wait_cnt", dut.wait_cnt, m_wait);
    check("igrant", igrant, eig);
    check("dgrant", dgrant, edg);
    check("mem_en", mem_en, eig || edg);
    check("mem_addr", mem_addr, eaddr);
    check("mem_we", mem_we, edg && we);
    check("mem_mask", mem_mask, (edg && we) ? mk : 4'b0);
    check("mem_data", mem_wdata, edg ? wd : 32'h0);

    r.owner = eig ? EXP_I : ((edg && !we) ? EXP_D : EXP_NONE);
    r.data  = ref_mem[eaddr[7:0]];
    sb.push_back(r);
    if (edg && we)
      for (int b = 0; b < 4; b++)
        if (mk[b]) ref_mem[da[7:0]][8*b +: 8] = wd[8*b +: 8];

    if (rst || !ir || eig) m_wait = 0;
    else if (m_wait < MW)  m_wait = m_wait + 1;

    // Reset mid-cycle: the just-granted read must never come back.
    if (pulse_rst) begin
      #2 rst = 1'b1;
      sb.delete();
      r.owner = EXP_NONE;
      r.data  = 32'h0;
      sb.push_back(r);
      m_wait = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, '0, 0, '0, 0, 4'h0, 32'h0, 0);
  endtask

  initial begin
    rsp_t r0;
    int ig_count;
    for (int a = 0; a < 256; a++) begin
      ram[a]     = 32'h1357_0000 + a * 32'h0001_0203;
      ref_mem[a] = 32'h1357_0000 + a * 32'h0001_0203;
    end
    r0.owner = EXP_NONE;
    r0.data  = 32'h0;
    sb.push_back(r0);

    // Reset state, with requests present: grants must stay low.
    cycle(1, 30'h10, 1, 30'h20, 0, 4'h0, 32'h0, 0);
    rst = 1'b0;
    idle(2);

    // I only: three back-to-back fetches of 0x10.
    for (int k = 0; k < 3; k++) cycle(1, 30'h10, 0, '0, 0, 4'h0, 32'h0, 0);
    idle(1);

    // D write low halfword of 0x20, then read it back.
    cycle(0, '0, 1, 30'h20, 1, 4'b0011, 32'hDEAD_BEEF, 0);
    cycle(0, '0, 1, 30'h20, 0, 4'h0, 32'h0, 0);
    idle(1);
    check("merged_word", ref_mem[8'h20], {ram[8'h20][31:16], 16'hBEEF});

    // Contention: period-5 pattern D D D D I; count I grants over 15 cycles.
    ig_count = 0;
    for (int k = 0; k < 15; k++) begin
      cycle(1, 30'h11 + 30'(k), 1, 30'h30, 0, 4'h0, 32'h0, 0);
      if (sb[0].owner == EXP_I) ig_count++;
    end
    check("contention_i_grants", ig_count, 3);
    idle(1);

    // Request drop: 2 denied cycles, I drops, then contention again.
    cycle(1, 30'h40, 1, 30'h41, 0, 4'h0, 32'h0, 0);
    cycle(1, 30'h40, 1, 30'h41, 0, 4'h0, 32'h0, 0);
    cycle(0, '0,     1, 30'h41, 0, 4'h0, 32'h0, 0);
    for (int k = 0; k < 5; k++) cycle(1, 30'h40, 1, 30'h42, 0, 4'h0, 32'h0, 0);
    check("drop_forced_i_5th", sb[0].owner, EXP_I);
    idle(1);

    // Reset mid-read: I granted, reset before the next edge.
    cycle(1, 30'h50, 0, '0, 0, 4'h0, 32'h0, 1);
    cycle(1, 30'h50, 1, 30'h51, 0, 4'h0, 32'h0, 0);
    rst = 1'b0;
    cycle(1, 30'h50, 0, '0, 0, 4'h0, 32'h0, 0);
    idle(1);

    // Random traffic across a small address window.
    for (int k = 0; k < 60; k++)
      cycle(1'($urandom_range(0, 1)), 30'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 30'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
